// File: rtl/monitor_host.sv
// Host-side initiator for the serial monitor protocol: sends a 3-byte header, checks echoes,
// streams load payload, collects dump bytes and reports done/err to a local controller.
module monitor_host #(
    parameter int unsigned TIMEOUT_CYCLES = 12000000,
    parameter int unsigned TO_WIDTH       = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [15:0] cmd_addr,
    input  logic [5:0] cmd_len,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic [7:0] tx_byte,
    output logic       transmit,
    input  logic       is_transmitting,
    input  logic       received,
    input  logic [7:0] rx_byte,
    output logic       busy,
    output logic       done,
    output logic [1:0] err
);
    localparam logic [1:0] OP_ILLEGAL = 2'b00;
    localparam logic [1:0] OP_LOAD    = 2'b01;
    localparam logic [1:0] OP_DUMP    = 2'b10;
    localparam logic [1:0] OP_EXEC    = 2'b11;
    localparam logic [TO_WIDTH-1:0] TO_RELOAD = TO_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, HDR_TX, HDR_ECHO, LOAD_GET, LOAD_TX, LOAD_ECHO,
        PAD_TX, PAD_DRAIN, DUMP_RX, EXEC_DRAIN, FINISH
    } state_t;

    state_t              state;
    logic [1:0]          op;
    logic [15:0]         addr;
    logic [5:0]          len;
    logic [5:0]          remaining;
    logic [1:0]          hdr_idx;
    logic [7:0]          data;
    logic [TO_WIDTH-1:0] timer;
    logic [7:0]          hdr_byte;
    logic                tx_free;
    logic                timed_out;

    always_comb begin
        hdr_byte = '0;
        case (hdr_idx)
            2'd0:    hdr_byte = addr[15:8];
            2'd1:    hdr_byte = addr[7:0];
            default: hdr_byte = {op, (op == OP_EXEC) ? 6'd0 : len};
        endcase
    end

    // transmit still high means the UART has not yet had a chance to raise is_transmitting
    assign tx_free   = !is_transmitting && !transmit;
    assign timed_out = (timer == '0);
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign wr_ready  = (state == LOAD_GET) && wr_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op        <= '0;
            addr      <= '0;
            len       <= '0;
            remaining <= '0;
            hdr_idx   <= '0;
            data      <= '0;
            timer     <= '0;
            tx_byte   <= '0;
            transmit  <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            done      <= 1'b0;
            err       <= '0;
        end else begin
            transmit <= 1'b0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            if (!timed_out) timer <= timer - 1'b1;
            case (state)
                IDLE: if (cmd_valid) begin
                    op        <= cmd_op;
                    addr      <= cmd_addr;
                    len       <= cmd_len;
                    remaining <= cmd_len;
                    hdr_idx   <= '0;
                    if (cmd_op == OP_ILLEGAL) begin
                        err <= 2'b11;
                    end else begin
                        err   <= 2'b00;
                        state <= HDR_TX;
                    end
                end
                HDR_TX: if (tx_free) begin
                    tx_byte  <= hdr_byte;
                    transmit <= 1'b1;
                    timer    <= TO_RELOAD;
                    state    <= HDR_ECHO;
                end
                HDR_ECHO: if (received) begin
                    if (rx_byte != tx_byte) begin
                        err   <= 2'b01;
                        state <= IDLE;
                    end else if (hdr_idx != 2'd2) begin
                        hdr_idx <= hdr_idx + 1'b1;
                        state   <= HDR_TX;
                    end else begin
                        case (op)
                            OP_LOAD: state <= (len == '0) ? PAD_TX : LOAD_GET;
                            OP_DUMP: begin
                                if (len == '0) begin
                                    done  <= 1'b1;
                                    state <= FINISH;
                                end else begin
                                    timer <= TO_RELOAD;
                                    state <= DUMP_RX;
                                end
                            end
                            default: state <= EXEC_DRAIN;
                        endcase
                    end
                end else if (timed_out) begin
                    err   <= 2'b10;
                    state <= IDLE;
                end
                LOAD_GET: if (wr_valid) begin
                    data  <= wr_data;
                    state <= LOAD_TX;
                end
                LOAD_TX: if (tx_free) begin
                    tx_byte  <= data;
                    transmit <= 1'b1;
                    timer    <= TO_RELOAD;
                    state    <= LOAD_ECHO;
                end
                LOAD_ECHO: if (received) begin
                    if (rx_byte != tx_byte) begin
                        err   <= 2'b01;
                        state <= IDLE;
                    end else begin
                        remaining <= remaining - 1'b1;
                        if (remaining == 6'd1) begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            state <= LOAD_GET;
                        end
                    end
                end else if (timed_out) begin
                    err   <= 2'b10;
                    state <= IDLE;
                end
                PAD_TX: if (tx_free) begin
                    tx_byte  <= 8'h00;
                    transmit <= 1'b1;
                    state    <= PAD_DRAIN;
                end
                PAD_DRAIN: if (tx_free) begin
                    done  <= 1'b1;
                    state <= FINISH;
                end
                DUMP_RX: if (received) begin
                    rd_data   <= rx_byte;
                    rd_valid  <= 1'b1;
                    remaining <= remaining - 1'b1;
                    timer     <= TO_RELOAD;
                    if (remaining == 6'd1) begin
                        done  <= 1'b1;
                        state <= FINISH;
                    end
                end else if (timed_out) begin
                    err   <= 2'b10;
                    state <= IDLE;
                end
                EXEC_DRAIN: if (!is_transmitting) begin
                    done  <= 1'b1;
                    state <= FINISH;
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_monitor_host.sv
// Self-checking bench for monitor_host: UART/remote model with echo, scoreboarded tx and dump bytes.
module tb_monitor_host;
    localparam int unsigned TO = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [15:0] cmd_addr = '0;
    logic [5:0]  cmd_len = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [7:0]  tx_byte;
    logic        transmit;
    logic        is_transmitting = 1'b0;
    logic        received = 1'b0;
    logic [7:0]  rx_byte = '0;
    logic        busy;
    logic        done;
    logic [1:0]  err;

    monitor_host #(.TIMEOUT_CYCLES(TO), .TO_WIDTH(24)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .tx_byte(tx_byte), .transmit(transmit),
        .is_transmitting(is_transmitting), .received(received), .rx_byte(rx_byte),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rd[$];
    logic [7:0] dump_q[$];
    logic [7:0] wr_q[$];
    int echo_count = 0, corrupt_idx = -1, tx_base = 0;
    int tx_cnt = 0, rd_cnt = 0, done_cnt = 0, wrr_cnt = 0, cyc = 0, last_rx_cyc = 0;
    int busy_cnt = 0, gap = 0;
    logic echo_pend = 1'b0, prev_tx = 1'b0, consumed = 1'b0;
    logic [7:0] echo_b = '0;
    int b_done, b_rd, b_wr, b_tx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Remote UART model, payload feeder and output monitors, all sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            received = 1'b0; is_transmitting = 1'b0; busy_cnt = 0; gap = 0;
            echo_pend = 1'b0; prev_tx = 1'b0; consumed = 1'b0; wr_valid = 1'b0;
        end else begin
            if (done) begin
                done_cnt++;
                check("done_tx_idle", is_transmitting, 0);
                check("done_before_ready", cmd_ready, 0);
            end
            if (rd_valid) begin
                rd_cnt++;
                check("rd_expected", exp_rd.size() > 0, 1);
                if (exp_rd.size() > 0) check("rd_data", rd_data, exp_rd.pop_front());
            end
            if (consumed) begin
                if (wr_q.size() > 0) void'(wr_q.pop_front());
                consumed = 1'b0;
            end else if (wr_ready) begin
                consumed = 1'b1;
                wrr_cnt++;
            end
            wr_valid = (wr_q.size() > 0);
            wr_data  = wr_valid ? wr_q[0] : 8'h00;

            received = 1'b0;
            if (transmit) begin
                check("no_back_to_back", prev_tx, 0);
                check("tx_expected", exp_tx.size() > 0, 1);
                if (exp_tx.size() > 0) check("tx_byte", tx_byte, exp_tx.pop_front());
                busy_cnt = 6;
                is_transmitting = 1'b1;
                echo_pend = ((tx_cnt - tx_base) < echo_count);
                echo_b = ((tx_cnt - tx_base) == corrupt_idx) ? 8'hFF : tx_byte;
                tx_cnt++;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    is_transmitting = 1'b0;
                    if (echo_pend) begin
                        received = 1'b1; rx_byte = echo_b; echo_pend = 1'b0;
                        if ((tx_cnt - tx_base) == 3 && dump_q.size() > 0) gap = 4;
                    end
                end
            end else if (gap > 0) begin
                gap--;
                if (gap == 0 && dump_q.size() > 0) begin
                    received = 1'b1; rx_byte = dump_q.pop_front(); last_rx_cyc = cyc;
                    if (dump_q.size() > 0) gap = 5;
                end
            end
            prev_tx = transmit;
        end
    end

    task automatic start(input int echoes, input int corrupt);
        echo_count = echoes; corrupt_idx = corrupt; tx_base = tx_cnt;
        b_done = done_cnt; b_rd = rd_cnt; b_wr = wrr_cnt; b_tx = tx_cnt;
    endtask

    task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [5:0] l);
        @(negedge clk);
        cmd_op = op; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 2000; i++) begin
            if (cmd_ready) break;
            @(negedge clk);
        end
        check({tag, "_returns_idle"}, cmd_ready, 1);
    endtask

    task automatic finish_cmd(input string tag, input int nd, input logic [1:0] e, input int nr,
                              input int nw, input int ntx);
        wait_idle(tag);
        repeat (3) @(negedge clk);
        check({tag, "_done"}, done_cnt - b_done, nd);
        check({tag, "_err"}, err, e);
        check({tag, "_rd_count"}, rd_cnt - b_rd, nr);
        check({tag, "_wr_ready_count"}, wrr_cnt - b_wr, nw);
        check({tag, "_tx_count"}, tx_cnt - b_tx, ntx);
        check({tag, "_tx_pending"}, exp_tx.size(), 0);
        check({tag, "_rd_pending"}, exp_rd.size(), 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_transmit", transmit, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_wr_ready", wr_ready, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        start(5, -1);
        exp_tx = '{8'h00, 8'h10, 8'h42, 8'hA5, 8'h3C};
        wr_q = '{8'hA5, 8'h3C};
        issue(2'b01, 16'h0010, 6'd2);
        finish_cmd("load2", 1, 2'b00, 0, 2, 5);

        start(3, -1);
        exp_tx = '{8'h00, 8'h20, 8'h83};
        exp_rd = '{8'h11, 8'h22, 8'h33};
        dump_q = '{8'h11, 8'h22, 8'h33};
        issue(2'b10, 16'h0020, 6'd3);
        finish_cmd("dump3", 1, 2'b00, 3, 0, 3);

        start(3, -1);
        exp_tx = '{8'h00, 8'h00, 8'hC0};
        issue(2'b11, 16'h0000, 6'd17);
        finish_cmd("exec", 1, 2'b00, 0, 0, 3);

        start(3, -1);
        exp_tx = '{8'h00, 8'h50, 8'h40, 8'h00};
        issue(2'b01, 16'h0050, 6'd0);
        finish_cmd("load0_pad", 1, 2'b00, 0, 0, 4);

        start(3, -1);
        exp_tx = '{8'h00, 8'h40, 8'h80};
        issue(2'b10, 16'h0040, 6'd0);
        finish_cmd("dump0", 1, 2'b00, 0, 0, 3);

        start(4, 3);
        exp_tx = '{8'h01, 8'h00, 8'h41, 8'h5A};
        wr_q = '{8'h5A};
        issue(2'b01, 16'h0100, 6'd1);
        finish_cmd("echo_bad", 0, 2'b01, 0, 1, 4);
        check("echo_bad_cmd_ready", cmd_ready, 1);

        start(3, -1);
        exp_tx = '{8'h00, 8'h30, 8'h82};
        exp_rd = '{8'h77};
        dump_q = '{8'h77};
        issue(2'b10, 16'h0030, 6'd2);
        wait_idle("dump_timeout");
        check("timeout_latency_in_window",
              ((cyc - last_rx_cyc) >= 95) && ((cyc - last_rx_cyc) <= 110), 1);
        finish_cmd("dump_timeout", 0, 2'b10, 1, 0, 3);

        start(0, -1);
        issue(2'b00, 16'h1234, 6'd5);
        finish_cmd("illegal", 0, 2'b11, 0, 0, 0);

        start(5, -1);
        exp_tx = '{8'h02, 8'h00, 8'h42, 8'h01, 8'h02};
        wr_q = '{8'h01, 8'h02};
        issue(2'b01, 16'h0200, 6'd2);
        for (int i = 0; i < 500; i++) begin
            if (wrr_cnt - b_wr >= 1) break;
            @(negedge clk);
        end
        check("midrst_reached_payload", (wrr_cnt - b_wr) >= 1, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_transmit", transmit, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        exp_tx.delete(); wr_q.delete(); dump_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_err", err, 0);

        start(3, -1);
        exp_tx = '{8'h12, 8'h34, 8'hC0};
        issue(2'b11, 16'h1234, 6'd0);
        finish_cmd("exec_after_rst", 1, 2'b00, 0, 0, 3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d passed", passed, checks);
        $fatal(1, "watchdog");
    end
endmodule
